// File: rtl/prim_rec_ctrl.sv
// Primitive-recursion controller: runs child g once, then child h n times,
// feeding each result back as prev, with abort, per-child timeout and progress count.
module prim_rec_ctrl #(
  parameter int unsigned W       = 16,
  parameter int unsigned NARGS   = 1,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ST,
  input  logic                 ABORT,
  input  logic [NARGS*W-1:0]   ARGS,
  input  logic [CNT_W-1:0]     N,
  output logic                 RD,
  output logic [W-1:0]         RES,
  output logic                 ERR,
  output logic [CNT_W-1:0]     ITER,
  output logic                 G_ST,
  output logic [NARGS*W-1:0]   G_ARGS,
  input  logic                 G_RD,
  input  logic [W-1:0]         G_RES,
  output logic                 H_ST,
  output logic [NARGS*W-1:0]   H_ARGS,
  output logic [CNT_W-1:0]     H_K,
  output logic [W-1:0]         H_PREV,
  input  logic                 H_RD,
  input  logic [W-1:0]         H_RES
);

  localparam int unsigned AW = NARGS * W;
  localparam int unsigned IW = CNT_W + 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_G_RUN, S_H_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             rd_q, rd_d;
  logic [W-1:0]     res_q, res_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             g_st_q, g_st_d;
  logic             h_st_q, h_st_d;
  logic [AW-1:0]    args_q, args_d;
  logic [CNT_W-1:0] nl_q, nl_d;
  logic [CNT_W-1:0] h_k_q, h_k_d;
  logic [W-1:0]     h_prev_q, h_prev_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic             st_q, g_rd_q, h_rd_q;

  logic             start_c, g_done_c, h_done_c, tmo_c;
  logic [IW-1:0]    iter_inc_c;

  // Rising-edge events; a level held over from an earlier job never fires.
  assign start_c    = ST & ~st_q;
  assign g_done_c   = G_RD & ~g_rd_q;
  assign h_done_c   = H_RD & ~h_rd_q;
  assign tmo_c      = (TIMEOUT != 0) && (wait_q == TW'(TIMEOUT));
  assign iter_inc_c = {1'b0, iter_q} + IW'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    res_d    = res_q;
    err_d    = err_q;
    iter_d   = iter_q;
    g_st_d   = 1'b0;
    h_st_d   = 1'b0;
    args_d   = args_q;
    nl_d     = nl_q;
    h_k_d    = h_k_q;
    h_prev_d = h_prev_q;
    wait_d   = wait_q;

    // Wait counter saturates at TIMEOUT; restarted to 1 with every child start.
    if (state_q != S_IDLE && TIMEOUT != 0 && wait_q != TW'(TIMEOUT)) begin
      wait_d = wait_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start_c && !ABORT) begin
          args_d  = ARGS;
          nl_d    = N;
          err_d   = 1'b0;
          iter_d  = '0;
          rd_d    = 1'b0;
          g_st_d  = 1'b1;
          wait_d  = TW'(1);
          state_d = S_G_RUN;
        end
      end
      S_G_RUN: begin
        if (ABORT || (tmo_c && !g_done_c)) begin
          rd_d    = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (g_done_c) begin
          if (nl_q == '0) begin
            res_d   = G_RES;
            rd_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            h_k_d    = '0;
            h_prev_d = G_RES;
            h_st_d   = 1'b1;
            wait_d   = TW'(1);
            state_d  = S_H_RUN;
          end
        end
      end
      S_H_RUN: begin
        if (ABORT || (tmo_c && !h_done_c)) begin
          rd_d    = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (h_done_c) begin
          iter_d = iter_inc_c[CNT_W-1:0];
          if (iter_inc_c == {1'b0, nl_q}) begin
            res_d   = H_RES;
            rd_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            h_k_d    = h_k_q + CNT_W'(1);
            h_prev_d = H_RES;
            h_st_d   = 1'b1;
            wait_d   = TW'(1);
          end
        end
      end
      S_DONE: begin
        rd_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      rd_q     <= 1'b1;
      res_q    <= '0;
      err_q    <= 1'b0;
      iter_q   <= '0;
      g_st_q   <= 1'b0;
      h_st_q   <= 1'b0;
      args_q   <= '0;
      nl_q     <= '0;
      h_k_q    <= '0;
      h_prev_q <= '0;
      wait_q   <= '0;
      st_q     <= 1'b0;
      g_rd_q   <= 1'b0;
      h_rd_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      res_q    <= res_d;
      err_q    <= err_d;
      iter_q   <= iter_d;
      g_st_q   <= g_st_d;
      h_st_q   <= h_st_d;
      args_q   <= args_d;
      nl_q     <= nl_d;
      h_k_q    <= h_k_d;
      h_prev_q <= h_prev_d;
      wait_q   <= wait_d;
      st_q     <= ST;
      g_rd_q   <= G_RD;
      h_rd_q   <= H_RD;
    end
  end

  assign RD     = rd_q;
  assign RES    = res_q;
  assign ERR    = err_q;
  assign ITER   = iter_q;
  assign G_ST   = g_st_q;
  assign G_ARGS = args_q;
  assign H_ST   = h_st_q;
  assign H_ARGS = args_q;
  assign H_K    = h_k_q;
  assign H_PREV = h_prev_q;

endmodule

// File: tb/tb_prim_rec_ctrl.sv
// Bench for prim_rec_ctrl: 3-cycle child models for g and h, closed-form
// reference f(y,n) = y + n(n+1)/2, directed steps plus randomized jobs.
module tb_prim_rec_ctrl;

  localparam int unsigned W       = 16;
  localparam int unsigned NARGS   = 2;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 st, abort;
  logic [NARGS*W-1:0]   args;
  logic [CNT_W-1:0]     n;
  logic                 rd, err, g_st, h_st;
  logic [W-1:0]         res, h_prev;
  logic [CNT_W-1:0]     iter, h_k;
  logic [NARGS*W-1:0]   g_args, h_args;
  logic                 g_rd = 1'b1, h_rd = 1'b1;
  logic [W-1:0]         g_res = '0, h_res = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prim_rec_ctrl #(.W(W), .NARGS(NARGS), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(clk), .RST(rst_n), .ST(st), .ABORT(abort), .ARGS(args), .N(n),
    .RD(rd), .RES(res), .ERR(err), .ITER(iter),
    .G_ST(g_st), .G_ARGS(g_args), .G_RD(g_rd), .G_RES(g_res),
    .H_ST(h_st), .H_ARGS(h_args), .H_K(h_k), .H_PREV(h_prev),
    .H_RD(h_rd), .H_RES(h_res)
  );

  // Child g: returns ARGS[0], 3 cycles after seeing its start.
  int         g_cnt = 0;
  logic [W-1:0] g_val = '0;
  always @(posedge clk) begin
    if (g_st) begin
      g_rd  <= 1'b0;
      g_cnt <= 3;
      g_val <= g_args[W-1:0];
    end else if (g_cnt != 0) begin
      g_cnt <= g_cnt - 1;
      if (g_cnt == 1) begin
        g_rd  <= 1'b1;
        g_res <= g_val;
      end
    end
  end

  // Child h: returns prev + k + 1; h_stuck freezes it with RD low.
  int         h_cnt = 0;
  logic [W-1:0] h_val = '0;
  logic       h_stuck = 1'b0;
  always @(posedge clk) begin
    if (h_st) begin
      h_rd  <= 1'b0;
      h_cnt <= 3;
      h_val <= h_prev + W'(h_k) + W'(1);
    end else if (h_cnt != 0 && !h_stuck) begin
      h_cnt <= h_cnt - 1;
      if (h_cnt == 1) begin
        h_rd  <= 1'b1;
        h_res <= h_val;
      end
    end
  end

  // Pulse monitor, sampled at the active edge (values from the cycle just ending).
  int           g_pulses = 0;
  int           h_pulses = 0;
  logic [CNT_W-1:0] hk_q[$];
  logic [W-1:0]     hp_q[$];
  always @(posedge clk) begin
    if (g_st) g_pulses++;
    if (h_st) begin
      h_pulses++;
      hk_q.push_back(h_k);
      hp_q.push_back(h_prev);
    end
  end

  // Value of prev entering step k: y plus the sum 1..k.
  function automatic logic [W-1:0] prev_at(input logic [W-1:0] y, input int k);
    return y + W'((k * (k + 1)) / 2);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rd(input string tag, input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (rd) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_rd_wait"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_h_pulses(input string tag, input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (h_pulses >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_h_wait"}, 64'(ok), 64'd1);
  endtask

  task automatic run_job(input string tag, input logic [W-1:0] y0, input logic [W-1:0] y1,
                         input int nn);
    int g0 = g_pulses;
    int h0 = h_pulses;
    hk_q.delete();
    hp_q.delete();
    @(negedge clk);
    args = {y1, y0};
    n    = CNT_W'(nn);
    st   = 1'b1;
    @(negedge clk);
    st = 1'b0;
    check({tag, "_busy"}, 64'(rd), 64'd0);
    wait_rd(tag, 400);
    check({tag, "_res"}, 64'(res), 64'(prev_at(y0, nn)));
    check({tag, "_iter"}, 64'(iter), 64'(nn));
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_g_pulses"}, 64'(g_pulses - g0), 64'd1);
    check({tag, "_h_pulses"}, 64'(h_pulses - h0), 64'(nn));
    for (int k = 0; k < hk_q.size() && k < nn; k++) begin
      check($sformatf("%s_hk%0d", tag, k), 64'(hk_q[k]), 64'(k));
      check($sformatf("%s_hprev%0d", tag, k), 64'(hp_q[k]), 64'(prev_at(y0, k)));
    end
  endtask

  initial begin
    int g0, h0, cyc;
    bit seen;
    rst_n = 1'b0;
    st    = 1'b0;
    abort = 1'b0;
    args  = '0;
    n     = '0;
    repeat (3) @(negedge clk);
    check("rst_rd", 64'(rd), 64'd1);
    check("rst_res", 64'(res), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_iter", 64'(iter), 64'd0);
    check("rst_g_st", 64'(g_st), 64'd0);
    check("rst_h_st", 64'(h_st), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_job("n0", 16'd5, 16'd0, 0);
    run_job("n4", 16'd5, 16'd0, 4);

    // Start edges while busy are consumed; held ST does not restart.
    g0 = g_pulses;
    h0 = h_pulses;
    @(negedge clk);
    args = {16'd0, 16'd5};
    n    = 16'd3;
    st   = 1'b1;
    @(negedge clk);
    st = 1'b0;
    wait_h_pulses("stbusy", h0 + 1);
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    @(negedge clk);
    st = 1'b1;
    @(negedge clk);
    check("stbusy_still_busy", 64'(rd), 64'd0);
    wait_rd("stbusy", 400);
    check("stbusy_res", 64'(res), 64'd11);
    repeat (10) @(negedge clk);
    check("stheld_g_pulses", 64'(g_pulses - g0), 64'd1);
    check("stheld_rd", 64'(rd), 64'd1);
    st = 1'b0;
    @(negedge clk);
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    check("restart_busy", 64'(rd), 64'd0);
    wait_rd("restart", 400);
    check("restart_g_pulses", 64'(g_pulses - g0), 64'd2);
    check("restart_res", 64'(res), 64'd11);

    // Abort on the second h step of an N=4 job.
    run_job("pre_abort", 16'd5, 16'd0, 4);
    h0 = h_pulses;
    @(negedge clk);
    n  = 16'd4;
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    wait_h_pulses("abort", h0 + 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_rd", 64'(rd), 64'd1);
    check("abort_err", 64'(err), 64'd1);
    check("abort_res", 64'(res), 64'd15);
    check("abort_iter", 64'(iter), 64'd1);
    repeat (10) @(negedge clk);
    check("abort_no_more_h", 64'(h_pulses - h0), 64'd2);
    @(negedge clk);
    n  = 16'd0;
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    check("abort_clear_err", 64'(err), 64'd0);
    wait_rd("after_abort", 400);
    check("after_abort_res", 64'(res), 64'd5);

    // ABORT in idle beats a simultaneous start.
    g0 = g_pulses;
    @(negedge clk);
    st    = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    st    = 1'b0;
    abort = 1'b0;
    check("idle_abort_rd", 64'(rd), 64'd1);
    repeat (4) @(negedge clk);
    check("idle_abort_no_g", 64'(g_pulses - g0), 64'd0);
    check("idle_abort_err", 64'(err), 64'd0);

    // Timeout: h never answers.
    h_stuck = 1'b1;
    @(negedge clk);
    args = {16'd0, 16'd5};
    n    = 16'd2;
    st   = 1'b1;
    @(negedge clk);
    st   = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (h_st) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("tmo_h_st_seen", 64'(seen), 64'd1);
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cyc++;
      if (rd) break;
    end
    check("tmo_cycles", 64'(cyc), 64'd8);
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_res", 64'(res), 64'd5);
    h_stuck = 1'b0;
    repeat (6) @(negedge clk);
    run_job("post_tmo", 16'd5, 16'd0, 1);

    // Asynchronous reset during G_RUN; the late g edge must be ignored.
    g0 = g_pulses;
    h0 = h_pulses;
    @(negedge clk);
    args = {16'd0, 16'd9};
    n    = 16'd2;
    st   = 1'b1;
    @(negedge clk);
    st = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_rd", 64'(rd), 64'd1);
    check("arst_res", 64'(res), 64'd0);
    check("arst_g_st", 64'(g_st), 64'd0);
    check("arst_iter", 64'(iter), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("late_g_rd", 64'(rd), 64'd1);
    check("late_g_res", 64'(res), 64'd0);
    check("late_g_pulses", 64'(g_pulses - g0), 64'd1);
    check("late_h_pulses", 64'(h_pulses - h0), 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_job($sformatf("rnd%0d", i), W'($urandom), W'($urandom), int'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prim_rec_ctrl.md
Name: prim_rec_ctrl

Overview:
- Parametrised primitive-recursion controller, the next generation of the per-node recursion blocks the tree parser emits.
- Computes f(y, n): runs g(y) once, then h(y, k, prev) for k = 0..n-1, feeding each result back as prev.
- g and h are external child nodes driven over ST/RD handshake ports, so one controller serves any tree.
- New relative to earlier nodes: generic width and argument count, explicit iteration index, ABORT, per-child timeout with ERR, and an ITER progress count.

Parameters:
- W, 16, data width of results and arguments
- NARGS, 1, number of passthrough arguments y packed on ARGS
- CNT_W, 16, width of recursion count N and index
- TIMEOUT, 0, maximum cycles to wait for one child RD edge; 0 = no timeout

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-low
- ST  in  1  start; acts on rising edge
- ABORT  in  1  level; cancels a running job
- ARGS  in  NARGS*W  passthrough arguments y, packed
- N  in  CNT_W  recursion count
- RD  out  1  ready/done, level
- RES  out  W  result
- ERR  out  1  last job aborted or timed out
- ITER  out  CNT_W  completed h iterations of the current/last job
- G_ST  out  1  g start pulse
- G_ARGS  out  NARGS*W  latched ARGS
- G_RD  in  1  g ready
- G_RES  in  W  g result
- H_ST  out  1  h start pulse
- H_ARGS  out  NARGS*W  latched ARGS
- H_K  out  CNT_W  current index k
- H_PREV  out  W  previous result
- H_RD  in  1  h ready
- H_RES  in  W  h result

Behaviour:
- Reset (RST=0, async): RD=1, RES=0, ERR=0, ITER=0, G_ST=0, H_ST=0, state IDLE; all edge-detect registers cleared.
- Edge detection: ST, G_RD and H_RD are registered each cycle.
  - A start event is ST=1 with previous sample 0.
  - A child done event is a child RD sample of 1 with previous sample 0. A child RD held high from an earlier job is not a done event.
- States: IDLE, G_RUN, H_RUN, DONE.
- IDLE, start event at edge t:
  - Latch ARGS to G_ARGS/H_ARGS and N to an internal NL.
  - Clear ERR and ITER.
  - At t+1: RD=0 and G_ST=1 for exactly one cycle; state G_RUN.
- G_RUN, g done event:
  - BUF<=G_RES.
  - If NL==0: RES<=G_RES, RD=1 next cycle, state IDLE.
  - Otherwise: H_K=0, H_PREV=BUF, H_ST pulses one cycle on the next cycle; state H_RUN.
- H_RUN, h done event:
  - BUF<=H_RES and ITER<=ITER+1.
  - If ITER+1==NL: RES<=H_RES, RD=1 next cycle, state IDLE.
  - Otherwise: H_K<=H_K+1, H_PREV<=H_RES, H_ST pulses next cycle.
- H_K and H_PREV are stable for the whole h run. H_K never exceeds NL-1, and no counter wraps, including NL = 2^CNT_W-1.
- Latency: N=0 gives RD high 1 cycle after the g done event. Each h step adds 1 cycle of controller overhead plus the child latency.
- ST while busy (RD=0) is ignored; its edge is consumed, so no start is queued.
- ABORT=1 while busy:
  - Next cycle RD=1, ERR=1, state IDLE, no further child starts; RES holds its previous value.
  - ABORT in IDLE has no effect, except that it beats a simultaneous start event, which is dropped.
- Timeout (TIMEOUT>0): a wait counter resets at every G_ST/H_ST pulse. When it reaches TIMEOUT with no done event, the controller behaves exactly as ABORT.
- Done event and ABORT in the same cycle: ABORT wins, and RES is not updated.
- Done events in IDLE, or from the child not currently running, are ignored.
- RST asserted mid-job: everything returns to reset values immediately. Any child still running is left to finish and its edge is ignored.

Test Plan:
- Test child models: g returns ARGS[0]; h returns H_PREV + H_K + 1; each child has a 3-cycle latency and drops RD on start.
- ARGS=5, N=0, start -> exactly one G_ST, no H_ST; RES=5, RD=1, ITER=0, ERR=0.
- ARGS=5, N=4 -> H_K sequence 0,1,2,3 with matching H_PREV 5,6,8,11; RES=15, ITER=4, exactly 4 H_ST pulses.
- N=3 run, second ST pulse during H_RUN plus ST held high after completion -> no extra G_ST, RES=11; a new job starts only after ST falls and rises again.
- ABORT asserted on the second h step of an N=4 job (previous RES=15) -> RD=1 next cycle, ERR=1, RES stays 15, no further H_ST; next start clears ERR.
- TIMEOUT=8 with an h model that never raises RD -> RD=1 and ERR=1 exactly 8 cycles after H_ST; a following normal N=1 job gives RES=6.
- RST pulled low during G_RUN -> RD=1, RES=0, G_ST=0 asynchronously; a late G_RD edge after release is ignored.
